mult_bcd_conv: RTL and testbench



---
 rtl/mult_bcd_conv_if.sv | 21 ++
 rtl/mult_bcd_conv.sv | 108 ++++++++++
 tb/tb_mult_bcd_conv.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mult_bcd_conv_if.sv
// Handshake/data bundle between mult_32 and the double-dabble BCD converter.
// The blank bus exists only when BCD_BLANK_EN is defined.
interface mult_bcd_conv_if #(
  parameter int IN_W  = 32,
  parameter int N_DIG = 10
);
  logic                 init;
  logic [IN_W-1:0]      bin;
  logic [4*N_DIG-1:0]   bcd;
  logic                 busy;
  logic                 done;
`ifdef BCD_BLANK_EN
  logic [N_DIG-1:0]     blank;

  modport master (output init, bin, input bcd, busy, done, blank);
  modport slave  (input init, bin, output bcd, busy, done, blank);
`else
  modport master (output init, bin, input bcd, busy, done);
  modport slave  (input init, bin, output bcd, busy, done);
`endif
endinterface

// File: rtl/mult_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) fed by mult_32.
// Optional leading-zero blanking output enabled by defining BCD_BLANK_EN.
module mult_bcd_conv #(
  parameter int IN_W  = 32,
  parameter int N_DIG = 10,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  mult_bcd_conv_if.slave   cvt
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IN_W-1:0]      sr_q;
  logic [4*N_DIG-1:0]   acc_q;
  logic [4*N_DIG-1:0]   bcd_q;
  logic                 busy_q;
  logic                 done_q;

  logic [4*N_DIG-1:0]        adj_d;
  logic [4*N_DIG+IN_W-1:0]   shift_d;

  // Add-3 correction on the pre-shift digits, then shift the whole chain left.
  always_comb begin
    adj_d = acc_q;
    for (int i = 0; i < N_DIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shift_d = {adj_d, sr_q} << 1;
  end

`ifdef BCD_BLANK_EN
  logic [N_DIG-1:0] blank_q;
  logic [N_DIG-1:0] blank_d;
  logic             allZero;

  // A digit is blanked when it and every more significant digit are zero; units never blank.
  always_comb begin
    blank_d = '0;
    allZero = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      allZero    = allZero && (acc_q[4*i +: 4] == 4'd0);
      blank_d[i] = allZero;
    end
  end

  assign cvt.blank = blank_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q <= {{(N_DIG-1){1'b1}}, 1'b0};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (cvt.init) begin
            sr_q    <= cvt.bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          acc_q <= shift_d[4*N_DIG+IN_W-1:IN_W];
          sr_q  <= shift_d[IN_W-1:0];
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IN_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef BCD_BLANK_EN
          blank_q <= blank_d;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cvt.bcd  = bcd_q;
  assign cvt.busy = busy_q;
  assign cvt.done = done_q;

endmodule

// File: tb/tb_mult_bcd_conv.sv
// Self-checking bench for mult_bcd_conv: directed and random values against a decimal reference model.
// Blank checks are compiled in when BCD_BLANK_EN is defined.
module tb_mult_bcd_conv;

  localparam int IN_W  = 32;
  localparam int N_DIG = 10;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_bcd_conv_if #(.IN_W(IN_W), .N_DIG(N_DIG)) cvt ();

  mult_bcd_conv #(.IN_W(IN_W), .N_DIG(N_DIG), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .cvt (cvt)
  );

  int total = 0;
  int bad   = 0;

  // Decimal digits by repeated division, units first.
  function automatic logic [39:0] refBcd(input longint unsigned v);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < N_DIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] refBlank(input longint unsigned v);
    logic [9:0]       b;
    longint unsigned  p;
    b = '0;
    p = 1;
    for (int i = 1; i < N_DIG; i++) begin
      p    = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion from IDLE; optionally re-pulses init at cycles 5 and 20.
  task automatic applyStimulus(input logic [31:0] v, input bit pokeInit,
                               output int lat, output int busyLow, output int bcdMoved);
    logic [39:0] prev;
    @(negedge clk);
    cvt.init = 1'b1;
    cvt.bin  = v;
    @(negedge clk);
    cvt.init = 1'b0;
    cvt.bin  = $urandom;
    prev     = cvt.bcd;
    lat      = 0;
    busyLow  = 0;
    bcdMoved = 0;
    while (cvt.done !== 1'b1 && lat < 60) begin
      if (cvt.busy !== 1'b1) busyLow++;
      if (cvt.bcd !== prev) bcdMoved++;
      cvt.init = (pokeInit && (lat == 5 || lat == 20));
      @(negedge clk);
      lat++;
    end
    cvt.init = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [31:0] v, input bit pokeInit);
    int lat, busyLow, bcdMoved;
    applyStimulus(v, pokeInit, lat, busyLow, bcdMoved);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
    checkOutput({tag, "_bcd"}, 64'(cvt.bcd), 64'(refBcd(64'(v))));
    checkOutput({tag, "_busyLow"}, 64'(busyLow), 64'd0);
    checkOutput({tag, "_bcdHeld"}, 64'(bcdMoved), 64'd0);
    checkOutput({tag, "_busyAtDone"}, 64'(cvt.busy), 64'd0);
`ifdef BCD_BLANK_EN
    checkOutput({tag, "_blank"}, 64'(cvt.blank), 64'(refBlank(64'(v))));
`endif
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, 64'(cvt.done), 64'd0);
    checkOutput({tag, "_bcdKept"}, 64'(cvt.bcd), 64'(refBcd(64'(v))));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [15:0] a, b;
    int n;

    rst      = 1'b1;
    cvt.init = 1'b0;
    cvt.bin  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_bcd", 64'(cvt.bcd), 64'd0);
    checkOutput("reset_busy", 64'(cvt.busy), 64'd0);
    checkOutput("reset_done", 64'(cvt.done), 64'd0);
`ifdef BCD_BLANK_EN
    checkOutput("reset_blank", 64'(cvt.blank), 64'(10'b1111111110));
`endif

    runAndCheck("p31369", 32'h0000_7A89, 1'b0);
    checkOutput("p31369_lit", 64'(cvt.bcd), 64'h00_0003_1369);
    runAndCheck("zero", 32'h0, 1'b0);
    runAndCheck("allOnes", 32'hFFFF_FFFF, 1'b0);
    checkOutput("allOnes_lit", 64'(cvt.bcd), 64'h42_9496_7295);
    runAndCheck("sq65535", 32'hFFFE_0001, 1'b0);
    checkOutput("sq65535_lit", 64'(cvt.bcd), 64'h42_9483_6225);

    // Product as mult_32 would deliver it on pp.
    a = 16'h00F7;
    b = 16'h007F;
    v = 32'(a) * 32'(b);
    runAndCheck("chain", v, 1'b0);

    runAndCheck("initIgnored", 32'h0098_7654, 1'b1);

    for (int i = 0; i < 10; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      runAndCheck("random", v, 1'b0);
    end

    @(negedge clk);
    cvt.init = 1'b1;
    cvt.bin  = 32'h1234_5678;
    @(negedge clk);
    cvt.init = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset_bcd", 64'(cvt.bcd), 64'd0);
    checkOutput("midReset_busy", 64'(cvt.busy), 64'd0);
    checkOutput("midReset_done", 64'(cvt.done), 64'd0);
`ifdef BCD_BLANK_EN
    checkOutput("midReset_blank", 64'(cvt.blank), 64'(10'b1111111110));
`endif
    runAndCheck("afterReset", 32'h1234_5678, 1'b0);
    checkOutput("afterReset_lit", 64'(cvt.bcd), 64'h03_0541_9896);

    // init held high: back-to-back conversions every IN_W+2 cycles.
    v = $urandom;
    @(negedge clk);
    cvt.init = 1'b1;
    cvt.bin  = v;
    n = 0;
    while (cvt.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_first", 64'(cvt.bcd), 64'(refBcd(64'(v))));
    n = 0;
    @(negedge clk);
    n++;
    while (cvt.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cvt.init = 1'b0;
    checkOutput("held_period", 64'(n), 64'(IN_W + 2));
    checkOutput("held_second", 64'(cvt.bcd), 64'(refBcd(64'(v))));
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
